// File: rtl/instr_sequencer_pkg.sv
// Purpose : shared types for the instruction sequencer (opcodes, ALU selects, FSM states).
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package instr_sequencer_pkg;

    // Two-bit opcode held in the top bits of every instruction word.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_SW  = 2'b11
    } opcode_t;

    // ALU operation selects presented on alu_op.
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_CMP   = 4'b0111;
    localparam logic [3:0] ALU_STORE = 4'b0000;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_MEM    = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // Opcode to ALU select mapping.
    function automatic logic [3:0] opcode_to_alu(input opcode_t op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_CMP:  return ALU_CMP;
            default: return ALU_STORE;
        endcase
    endfunction

    // busy is high everywhere except the two parked states.
    function automatic logic state_is_busy(input state_t s);
        return !((s == S_IDLE) || (s == S_ERROR));
    endfunction

endpackage

// File: rtl/instr_sequencer_op_decode.sv
// Purpose : combinational opcode to ALU-select decoder.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; output follows input.
// Ports   : i_opcode  - opcode field of the instruction register
//           o_alu_op  - ALU operation select
module op_decode
    import instr_sequencer_pkg::*;
(
    input  opcode_t    i_opcode,
    output logic [3:0] o_alu_op
);

    always_comb begin
        o_alu_op = opcode_to_alu(i_opcode);
    end

endmodule

// File: rtl/instr_sequencer.sv
// Purpose : multi-cycle instruction sequencer (fetch/decode/exec/writeback or store) with ack timeouts.
// Latency : 4 cycles per instruction minimum (FETCH, DECODE, EXEC, WB or MEM) with first-cycle acks.
// Backpr. : FETCH holds imem_req until imem_ack, MEM holds dmem_we until dmem_ack; MAX_WAIT missed acks park in ERROR.
// Ports   : clk, rst_n (async active-low)      - clock and reset
//           start / stop                        - run control (start in IDLE/ERROR, stop at WB/MEM exit)
//           imem_req / imem_ack / imem_rdata    - instruction fetch handshake
//           dmem_we / dmem_ack                  - data store handshake
//           pc / ir / alu_op / reg_write        - datapath control outputs
//           busy / err                          - status (err is sticky until restarted)
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         alu_op,
    output logic               reg_write,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               busy,
    output logic               err
);

    // Counter must be able to hold MAX_WAIT itself.
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // Count value during the last allowed un-acked cycle; a miss here reaches MAX_WAIT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [3:0]          r_alu_op;
    logic                r_imem_req;
    logic                r_dmem_we;
    logic                r_reg_write;
    logic                r_busy;
    logic                r_err;

    state_t              w_next;
    logic                w_ir_load;
    logic                w_pc_inc;
    opcode_t             w_opcode;
    logic [3:0]          w_alu_op;

    assign w_opcode = opcode_t'(r_ir[INSTR_W-1 -: 2]);

    op_decode u_op_decode (
        .i_opcode (w_opcode),
        .o_alu_op (w_alu_op)
    );

    // Next-state decision. An ack in the final allowed cycle is tested
    // before the timeout so the ack always wins the tie.
    always_comb begin
        w_next    = r_state;
        w_ir_load = 1'b0;
        w_pc_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_next    = S_DECODE;
                    w_ir_load = 1'b1;
                end else if (r_wait == WAIT_LAST) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = (w_opcode == OP_SW) ? S_MEM : S_WB;
            end
            S_WB: begin
                w_pc_inc = 1'b1;
                w_next   = stop ? S_IDLE : S_FETCH;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    w_pc_inc = 1'b1;
                    w_next   = stop ? S_IDLE : S_FETCH;
                end else if (r_wait == WAIT_LAST) begin
                    w_next = S_ERROR;
                end
            end
            S_ERROR: begin
                if (start) w_next = S_FETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State plus every output register. Strobes are computed from the
    // state being entered, so each one is a pure function of r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_pc        <= '0;
            r_ir        <= '0;
            r_alu_op    <= ALU_STORE;
            r_imem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_reg_write <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_imem_req  <= (w_next == S_FETCH);
            r_dmem_we   <= (w_next == S_MEM);
            r_reg_write <= (w_next == S_WB);
            r_busy      <= state_is_busy(w_next);

            // Fresh count on each entry to a waiting state; otherwise count misses.
            if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))) begin
                r_wait <= '0;
            end else if (((r_state == S_FETCH) && !imem_ack) ||
                         ((r_state == S_MEM) && !dmem_ack)) begin
                r_wait <= r_wait + 1'b1;
            end

            if (w_ir_load) r_ir <= imem_rdata;
            if (w_pc_inc)  r_pc <= r_pc + 1'b1;

            // alu_op is captured on entry to EXEC and held through WB/MEM.
            if (w_next == S_EXEC) r_alu_op <= w_alu_op;

            if ((w_next == S_ERROR) && (r_state != S_ERROR)) begin
                r_err <= 1'b1;
            end else if ((r_state == S_ERROR) && start) begin
                r_err <= 1'b0;
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign dmem_we   = r_dmem_we;
    assign reg_write = r_reg_write;
    assign busy      = r_busy;
    assign err       = r_err;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign alu_op    = r_alu_op;

endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose : randomized self-checking bench for instr_sequencer against a per-instruction phase model.
// Latency : checks the 4-cycle minimum and every ack-delay/timeout path.
// Backpr. : drives random imem/dmem ack delays, including exact-limit and timeout cases.
module tb_instr_sequencer;

    localparam int PC_W     = 8;
    localparam int INSTR_W  = 16;
    localparam int MAX_WAIT = 15;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               imem_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         alu_op;
    logic               reg_write;
    logic               dmem_we;
    logic               dmem_ack;
    logic               busy;
    logic               err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the pc the sequencer should be presenting.
    logic [PC_W-1:0] exp_pc = '0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .ir         (ir),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .busy       (busy),
        .err        (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Spec table of opcode -> ALU select.
    function automatic logic [3:0] exp_alu(input logic [1:0] op);
        case (op)
            2'b00:   return 4'b0010;
            2'b01:   return 4'b0110;
            2'b10:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    // Called in the cycle after the final missed ack: sequencer sits in ERROR.
    task automatic recover_from_error();
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check_eq("err_set",       err,       1);
        check_eq("err_busy",      busy,      0);
        check_eq("err_imem_req",  imem_req,  0);
        check_eq("err_dmem_we",   dmem_we,   0);
        check_eq("err_reg_write", reg_write, 0);
        check_eq("err_pc",        pc,        exp_pc);
        start = 1'b0;
        stop  = 1'($urandom);
        @(negedge clk);
        check_eq("err_hold",      err,       1);
        check_eq("err_hold_busy", busy,      0);
        start = 1'b1;
        stop  = 1'($urandom);
    endtask

    // Runs one instruction starting from the cycle the sequencer enters FETCH.
    // fw/mw: number of missed ack cycles before the ack (>= MAX_WAIT means never).
    // stp: stop value at the WB/MEM exit. rst_at: MEM cycle in which to pulse reset (-1 none).
    task automatic run_instr(input logic [INSTR_W-1:0] instr, input int fw, input int mw,
                             input bit stp, input int rst_at);
        logic [3:0] ea;
        logic [1:0] op;
        op = instr[INSTR_W-1 -: 2];
        ea = exp_alu(op);

        for (int k = 0; k < MAX_WAIT; k++) begin
            @(negedge clk);
            check_eq("fetch_req",   imem_req,  1);
            check_eq("fetch_busy",  busy,      1);
            check_eq("fetch_err",   err,       0);
            check_eq("fetch_rw",    reg_write, 0);
            check_eq("fetch_we",    dmem_we,   0);
            check_eq("fetch_pc",    pc,        exp_pc);
            start      = 1'($urandom);
            stop       = 1'($urandom);
            dmem_ack   = 1'b0;
            imem_ack   = (k == fw);
            imem_rdata = (k == fw) ? instr : INSTR_W'($urandom);
            if (k == fw) break;
        end
        if (fw >= MAX_WAIT) begin
            recover_from_error();
            return;
        end

        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("dec_req",  imem_req,  0);
        check_eq("dec_rw",   reg_write, 0);
        check_eq("dec_we",   dmem_we,   0);
        check_eq("dec_busy", busy,      1);
        check_eq("dec_ir",   ir,        instr);
        start = 1'($urandom);
        stop  = 1'($urandom);

        @(negedge clk);
        check_eq("exec_alu", alu_op,    ea);
        check_eq("exec_rw",  reg_write, 0);
        check_eq("exec_we",  dmem_we,   0);
        check_eq("exec_req", imem_req,  0);
        start = 1'($urandom);
        stop  = 1'($urandom);

        if (op == 2'b11) begin
            for (int k = 0; k < MAX_WAIT; k++) begin
                @(negedge clk);
                check_eq("mem_we",  dmem_we,   1);
                check_eq("mem_rw",  reg_write, 0);
                check_eq("mem_req", imem_req,  0);
                check_eq("mem_pc",  pc,        exp_pc);
                check_eq("mem_alu", alu_op,    ea);
                start    = 1'($urandom);
                dmem_ack = (k == mw);
                stop     = (k == mw) ? stp : 1'($urandom);
                if (k == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check_eq("rst_we",   dmem_we,   0);
                    check_eq("rst_busy", busy,      0);
                    check_eq("rst_rw",   reg_write, 0);
                    check_eq("rst_req",  imem_req,  0);
                    check_eq("rst_pc",   pc,        exp_pc);
                    check_eq("rst_ir",   ir,        0);
                    dmem_ack = 1'b0;
                    @(posedge clk);
                    #1;
                    check_eq("rst_hold_we", dmem_we, 0);
                    check_eq("rst_hold_pc", pc,      exp_pc);
                    @(negedge clk);
                    rst_n = 1'b1;
                    start = 1'b1;
                    stop  = 1'b0;
                    return;
                end
                if (k == mw) break;
            end
            if (mw >= MAX_WAIT) begin
                recover_from_error();
                return;
            end
        end else begin
            @(negedge clk);
            check_eq("wb_rw",   reg_write, 1);
            check_eq("wb_alu",  alu_op,    ea);
            check_eq("wb_we",   dmem_we,   0);
            check_eq("wb_req",  imem_req,  0);
            check_eq("wb_busy", busy,      1);
            start = 1'($urandom);
            stop  = stp;
        end

        exp_pc = exp_pc + 1'b1;

        if (stp) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            check_eq("idle_busy", busy,      0);
            check_eq("idle_req",  imem_req,  0);
            check_eq("idle_rw",   reg_write, 0);
            check_eq("idle_we",   dmem_we,   0);
            check_eq("idle_err",  err,       0);
            check_eq("idle_pc",   pc,        exp_pc);
            start = 1'b0;
            stop  = 1'($urandom);
            @(negedge clk);
            check_eq("idle_hold_busy", busy,     0);
            check_eq("idle_hold_req",  imem_req, 0);
            start = 1'b1;
        end
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return MAX_WAIT;
        if (r == 1) return MAX_WAIT - 1;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;

        #12;
        check_eq("reset_pc",   pc,        0);
        check_eq("reset_ir",   ir,        0);
        check_eq("reset_alu",  alu_op,    0);
        check_eq("reset_rw",   reg_write, 0);
        check_eq("reset_req",  imem_req,  0);
        check_eq("reset_we",   dmem_we,   0);
        check_eq("reset_busy", busy,      0);
        check_eq("reset_err",  err,       0);

        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;

        // Store aborted by reset in its third MEM cycle.
        run_instr(16'hC000, 0, 5, 1'b0, 2);
        // Add with first-cycle ack: WB in cycle 4, pc -> 1.
        run_instr(16'h0000, 0, 0, 1'b0, -1);
        // Store with dmem_ack delayed 3 cycles.
        run_instr(16'hC000, 0, 3, 1'b0, -1);
        // Fetch timeout, then restart at the same pc.
        run_instr(16'h4123, MAX_WAIT, 0, 1'b0, -1);
        // Ack in the last allowed fetch cycle.
        run_instr(16'h8001, MAX_WAIT - 1, 0, 1'b0, -1);
        // Store timeout in MEM.
        run_instr(16'hC0FF, 1, MAX_WAIT, 1'b0, -1);
        // Stop at WB exit (stop toggles randomly during FETCH beforehand).
        run_instr(16'h0000, 2, 0, 1'b1, -1);

        // Random run, long enough to wrap pc past 0xFF.
        for (int i = 0; i < 320; i++) begin
            run_instr(INSTR_W'($urandom), rand_wait(), rand_wait(),
                      ($urandom_range(0, 4) == 0), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning the program counter width.
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning the instruction width; the opcode SHALL be bits [INSTR_W-1:INSTR_W-2].
REQ-003 The block SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of wait cycles for a memory acknowledge.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin or resume execution
- stop  in  1  return to IDLE at the next instruction boundary
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction memory acknowledge
- imem_rdata  in  INSTR_W  fetched instruction
- pc  out  PC_W  program counter
- ir  out  INSTR_W  instruction register
- alu_op  out  4  ALU operation select
- reg_write  out  1  register-file write strobe
- dmem_we  out  1  data-memory store request
- dmem_ack  in  1  data-memory acknowledge
- busy  out  1  high in any state except IDLE and ERROR
- err  out  1  sticky timeout flag

Function
REQ-005 The state machine SHALL have the states IDLE, FETCH, DECODE, EXEC, WB, MEM and ERROR.
REQ-006 In IDLE with start=1, the next state SHALL be FETCH; otherwise the block SHALL stay in IDLE.
REQ-007 FETCH SHALL hold imem_req=1; on imem_ack=1, ir SHALL load imem_rdata and the next state SHALL be DECODE.
REQ-008 DECODE SHALL last exactly one cycle and then go to EXEC.
REQ-009 EXEC SHALL last one cycle and drive alu_op from the opcode as follows: 00 -> 0010 (add), 01 -> 0110 (sub), 10 -> 0111 (compare), 11 -> 0000 (store).
REQ-010 From EXEC, opcodes 00, 01 and 10 SHALL go to WB, and opcode 11 SHALL go to MEM.
REQ-011 WB SHALL assert reg_write for exactly one cycle and keep alu_op at the EXEC value.
REQ-012 MEM SHALL hold dmem_we=1 until dmem_ack=1; reg_write SHALL be 0 throughout MEM.
REQ-013 Leaving WB, or leaving MEM on dmem_ack, SHALL increment pc by 1 modulo 2^PC_W, so the maximum value wraps to 0.
REQ-014 At the exit of WB or MEM, the next state SHALL be IDLE if stop=1 in that cycle, and FETCH otherwise.
REQ-015 Minimum instruction latency, with acknowledges on the first request cycle, SHALL be 4 cycles (FETCH, DECODE, EXEC, WB or MEM).
REQ-016 A wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle without an acknowledge.
REQ-017 When the wait counter reaches MAX_WAIT without an acknowledge, the next state SHALL be ERROR and err SHALL be set.
REQ-018 If an acknowledge arrives in the same cycle the counter reaches MAX_WAIT, the acknowledge SHALL win and no error SHALL be raised.
REQ-019 In ERROR, all request and strobe outputs SHALL be 0; start=1 SHALL clear err, keep pc, and go to FETCH.
REQ-020 The stop input SHALL be ignored in every state except at the WB and MEM exits.
REQ-021 The start input SHALL be ignored in every state except IDLE and ERROR.
REQ-022 imem_req, dmem_we and reg_write SHALL be Moore outputs, decoded from state only.

Reset
REQ-023 On rst_n=0, asynchronously: state=IDLE, pc=0, ir=0, alu_op=0000, reg_write=0, imem_req=0, dmem_we=0, busy=0, err=0, wait counter=0.
REQ-024 Reset asserted mid-instruction SHALL abort it with no further strobes, and no pc increment SHALL be committed.
REQ-025 The first state transition after reset release SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-026 A shared package SHALL hold the opcode enum (ADD, SUB, CMP, SW), the alu_op constants (0010, 0110, 0111, 0000) and the state enum.
REQ-027 The opcode-to-alu_op mapping SHALL be a combinational sub-module named op_decode, instantiated once.

Verification
REQ-028 Reset, then start pulse, imem_rdata=0x0000, ack on first request -> reg_write high in cycle 4, alu_op=0010, pc=1 after WB.
REQ-029 Instruction 0xC000 (store), dmem_ack delayed 3 cycles -> dmem_we high exactly 4 cycles, reg_write never high, pc increments once.
REQ-030 imem_ack held low with MAX_WAIT=15 -> ERROR after 15 wait cycles, err=1, busy=0; then start -> err=0 and FETCH at the same pc.
REQ-031 imem_ack arriving in exactly wait cycle 15 -> no error, DECODE next.
REQ-032 pc preloaded to 0xFF via a run of instructions, then one more instruction -> pc=0x00; stop held during FETCH -> ignored, IDLE only after WB.
REQ-033 rst_n dropped during MEM -> dmem_we=0 immediately, pc unchanged, state IDLE.
